demux32_write_bank: RTL

DEMUX32_WRITE_BANK -- requirements
Module: demux32_write_bank

---
 rtl/demux32_write_bank_pkg.sv | 13 +
 rtl/demux32_write_bank_decoder.sv | 19 +
 rtl/demux32_write_bank.sv | 88 ++++++++
 3 files changed

// File: rtl/demux32_write_bank_pkg.sv
// Shared defaults and FSM state type for the demux32 write bank.
package demux32_write_bank_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/demux32_write_bank_decoder.sv
// Address to one-hot word-enable decoder; all outputs low when en is low.
// Latency: combinational. Backpressure: none.
module decoder_5x32 #(
  parameter int AW = 5,
  parameter int N  = 32
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (addr == AW'(i));
    end
  end

endmodule

// File: rtl/demux32_write_bank.sv
// Register bank with one-hot demuxed writes and a DEPTH-cycle clear sweep.
// Latency: write visible on Q and WR_ACK one cycle after acceptance.
// Backpressure: W_READY low while sweeping or when a clear is requested.
module demux32_write_bank
  import demux32_write_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        W_VALID,
  output logic                        W_READY,
  input  logic [ADDR_WIDTH-1:0]       W_ADDR,
  input  logic [DATA_WIDTH-1:0]       W_DATA,
  output logic                        WR_ACK,
  input  logic                        CLR_REQ,
  output logic                        BUSY,
  output logic                        CLR_DONE,
  output logic [DEPTH*DATA_WIDTH-1:0] Q
);

  localparam int NDEC = 1 << ADDR_WIDTH;

  state_t                                state;
  logic [ADDR_WIDTH-1:0]                 cnt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]      mem;
  logic [NDEC-1:0]                       wr_en;
  logic                                  wr_fire;

  assign W_READY = (state == IDLE) && !CLR_REQ;
  assign wr_fire = W_VALID && W_READY;
  assign BUSY    = (state == CLEAR);
  assign Q       = mem;

  // Decoder spans the full address space; enables at or above DEPTH select nothing.
  decoder_5x32 #(
    .AW (ADDR_WIDTH),
    .N  (NDEC)
  ) u_dec (
    .addr   (W_ADDR),
    .en     (wr_fire),
    .onehot (wr_en)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      WR_ACK   <= 1'b0;
      CLR_DONE <= 1'b0;
      mem      <= '0;
    end else begin
      WR_ACK   <= wr_fire;
      CLR_DONE <= 1'b0;

      case (state)
        IDLE: begin
          if (CLR_REQ) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            CLR_DONE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Word 0 is never written when it is the hardwired zero register.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i] && !(ZERO_REG != 0 && i == 0)) begin
          mem[i] <= W_DATA;
        end
      end
    end
  end

endmodule
